// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared definitions for the two-digit multiplexed 7-segment controller:
//   - estado_t    : scan FSM states
//   - SEG_*       : active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   - AN_*        : active-low anode patterns, bit0 units, bit1 tens
//   - ANCHO_CNT   : width of the refresh counter
// ---------------------------------------------------------------------------
package display_pkg;

    localparam int ANCHO_CNT = 16;

    typedef enum logic [1:0] {
        INICIO   = 2'd0,
        UNIDADES = 2'd1,
        DECENAS  = 2'd2
    } estado_t;

    localparam logic [6:0] SEG_0        = 7'b1000000;
    localparam logic [6:0] SEG_1        = 7'b1111001;
    localparam logic [6:0] SEG_2        = 7'b0100100;
    localparam logic [6:0] SEG_3        = 7'b0110000;
    localparam logic [6:0] SEG_4        = 7'b0011001;
    localparam logic [6:0] SEG_5        = 7'b0010010;
    localparam logic [6:0] SEG_6        = 7'b0000010;
    localparam logic [6:0] SEG_7        = 7'b1111000;
    localparam logic [6:0] SEG_8        = 7'b0000000;
    localparam logic [6:0] SEG_9        = 7'b0010000;
    localparam logic [6:0] SEG_GUION    = 7'b0111111;
    localparam logic [6:0] SEG_APAGADO  = 7'b1111111;

    localparam logic [1:0] AN_NINGUNO   = 2'b11;
    localparam logic [1:0] AN_UNIDADES  = 2'b10;
    localparam logic [1:0] AN_DECENAS   = 2'b01;

endpackage

// File: rtl/bcd_a_7seg.sv
// ---------------------------------------------------------------------------
// bcd_a_7seg
// Combinational BCD nibble to active-low 7-segment encoder.
// Ports:
//   nibble    in  [3:0]  digit value; 10..15 are not BCD and show a dash
//   segmentos out [6:0]  active-low segments {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module bcd_a_7seg
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segmentos
);

    always_comb begin
        case (nibble)
            4'd0:    segmentos = SEG_0;
            4'd1:    segmentos = SEG_1;
            4'd2:    segmentos = SEG_2;
            4'd3:    segmentos = SEG_3;
            4'd4:    segmentos = SEG_4;
            4'd5:    segmentos = SEG_5;
            4'd6:    segmentos = SEG_6;
            4'd7:    segmentos = SEG_7;
            4'd8:    segmentos = SEG_8;
            4'd9:    segmentos = SEG_9;
            default: segmentos = SEG_GUION;
        endcase
    end

endmodule

// File: rtl/controlador_display.sv
// ---------------------------------------------------------------------------
// controlador_display
// Two-digit multiplexed 7-segment display controller with a one-entry
// pending register. New data is accepted with a valid/ready handshake and
// is only promoted to the visible display register at a frame boundary
// (the edge entering UNIDADES), so a frame never mixes old and new digits.
//
// Parameters:
//   DIV_REFRESCO  clk cycles each digit stays lit per scan slot (2..65535)
// Ports:
//   clk         in        sole clock, rising edge
//   rst_n       in        asynchronous active-low reset
//   DatoBCD     in  [7:0] packed BCD, [7:4] tens, [3:0] units
//   DatoValido  in        producer has valid DatoBCD
//   Listo       out       block accepts DatoBCD this cycle
//   Segmentos   out [6:0] active-low segments {g,f,e,d,c,b,a}
//   Anodos      out [1:0] active-low digit enables, bit0 units, bit1 tens
// Configuration:
//   BLANQUEO_CEROS_EN  when defined, a leading-zero tens digit is blanked
//                      (anodes off) while keeping slot timing unchanged.
// ---------------------------------------------------------------------------
module controlador_display
    import display_pkg::*;
#(
    parameter int DIV_REFRESCO = 1000
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] DatoBCD,
    input  logic       DatoValido,
    output logic       Listo,
    output logic [6:0] Segmentos,
    output logic [1:0] Anodos
);

    localparam logic [ANCHO_CNT-1:0] CNT_MAX = ANCHO_CNT'(DIV_REFRESCO - 1);

    estado_t              estado_q, estado_d;
    logic [ANCHO_CNT-1:0] cnt_q, cnt_d;
    logic [7:0]           disp_q, disp_d;
    logic [7:0]           pend_q, pend_d;
    logic                 pend_lleno_q, pend_lleno_d;
    logic                 listo_q, listo_d;
    logic [6:0]           seg_q, seg_d;
    logic [1:0]           anodos_q, anodos_d;

    logic                 frontera;
    logic                 transferencia;
    logic [3:0]           nibble;
    logic [6:0]           seg_cod;

    // Next-state, counter and data-path registers.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        estado_d     = estado_q;
        cnt_d        = cnt_q;
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_lleno_d = pend_lleno_q;
        frontera     = 1'b0;

        case (estado_q)
            INICIO: begin
                estado_d = UNIDADES;
                cnt_d    = '0;
                frontera = 1'b1;
            end
            UNIDADES: begin
                if (cnt_q == CNT_MAX) begin
                    estado_d = DECENAS;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DECENAS: begin
                if (cnt_q == CNT_MAX) begin
                    estado_d = UNIDADES;
                    cnt_d    = '0;
                    frontera = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                estado_d = INICIO;
                cnt_d    = '0;
            end
        endcase

        transferencia = DatoValido && listo_q;

        // Promote first, then capture: a transfer on the boundary edge can
        // only happen with the pending slot empty, so it lands in pending
        // and is shown from the following frame.
        if (frontera && pend_lleno_q) begin
            disp_d       = pend_q;
            pend_lleno_d = 1'b0;
        end
        if (transferencia) begin
            pend_d       = DatoBCD;
            pend_lleno_d = 1'b1;
        end

        listo_d = (estado_d != INICIO) && !pend_lleno_d;
    end

    // Outputs are computed from next-state values so the registered
    // Segmentos/Anodos change on the same edge as the state.
    assign nibble = (estado_d == DECENAS) ? disp_d[7:4] : disp_d[3:0];

    bcd_a_7seg u_bcd_a_7seg (
        .nibble    (nibble),
        .segmentos (seg_cod)
    );

    always_comb begin
        anodos_d = AN_NINGUNO;
        seg_d    = SEG_APAGADO;
        case (estado_d)
            UNIDADES: begin
                anodos_d = AN_UNIDADES;
                seg_d    = seg_cod;
            end
            DECENAS: begin
`ifdef BLANQUEO_CEROS_EN
                if (disp_d[7:4] != 4'd0) begin
                    anodos_d = AN_DECENAS;
                    seg_d    = seg_cod;
                end
`else
                anodos_d = AN_DECENAS;
                seg_d    = seg_cod;
`endif
            end
            default: begin
                anodos_d = AN_NINGUNO;
                seg_d    = SEG_APAGADO;
            end
        endcase
    end

    // Single state register for FSM, data path and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q     <= INICIO;
            cnt_q        <= '0;
            disp_q       <= 8'h00;
            pend_q       <= 8'h00;
            pend_lleno_q <= 1'b0;
            listo_q      <= 1'b0;
            seg_q        <= SEG_APAGADO;
            anodos_q     <= AN_NINGUNO;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            estado_q     <= estado_d;
            cnt_q        <= cnt_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_lleno_q <= pend_lleno_d;
            listo_q      <= listo_d;
            seg_q        <= seg_d;
            anodos_q     <= anodos_d;
        end
    end

    assign Listo     = listo_q;
    assign Segmentos = seg_q;
    assign Anodos    = anodos_q;

endmodule

// File: tb/tb_controlador_display.sv
// ---------------------------------------------------------------------------
// tb_controlador_display
// Directed bench for controlador_display with DIV_REFRESCO=4: each slot is
// four cycles, a full frame eight. Edge numbers in comments count rising
// edges after reset release (E1 = entry into the first UNIDADES slot).
// ---------------------------------------------------------------------------
module tb_controlador_display;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] DatoBCD;
    logic       DatoValido;
    logic       Listo;
    logic [6:0] Segmentos;
    logic [1:0] Anodos;

    int checks = 0;
    int errors = 0;

    controlador_display #(.DIV_REFRESCO(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .DatoBCD    (DatoBCD),
        .DatoValido (DatoValido),
        .Listo      (Listo),
        .Segmentos  (Segmentos),
        .Anodos     (Anodos)
    );

    always #5 clk = ~clk;

    // Expected segment patterns, active-low {g,f,e,d,c,b,a}.
    localparam logic [6:0] S0    = 7'b1000000;
    localparam logic [6:0] S1    = 7'b1111001;
    localparam logic [6:0] S2    = 7'b0100100;
    localparam logic [6:0] S3    = 7'b0110000;
    localparam logic [6:0] S4    = 7'b0011001;
    localparam logic [6:0] S5    = 7'b0010010;
    localparam logic [6:0] S7    = 7'b1111000;
    localparam logic [6:0] SDASH = 7'b0111111;
    localparam logic [6:0] SOFF  = 7'b1111111;

`ifdef BLANQUEO_CEROS_EN
    localparam logic [1:0] AN_T0  = 2'b11;
    localparam logic [6:0] SEG_T0 = SOFF;
`else
    localparam logic [1:0] AN_T0  = 2'b01;
    localparam logic [6:0] SEG_T0 = S0;
`endif

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [1:0] an, input logic [6:0] seg,
                             input logic listo);
        check({tag, ".anodos"}, {6'd0, Anodos}, {6'd0, an});
        check({tag, ".seg"},    {1'b0, Segmentos}, {1'b0, seg});
        check({tag, ".listo"},  {7'd0, Listo}, {7'd0, listo});
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] dato);
        DatoBCD    = dato;
        DatoValido = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        DatoBCD    = 8'h00;
        DatoValido = 1'b0;

        tick(2);
        check_out("reset", 2'b11, SOFF, 1'b0);

        rst_n = 1'b1;
        #1;
        check_out("inicio", 2'b11, SOFF, 1'b0);

        tick(1);                                  // E1: UNIDADES, display 00
        check_out("first_units", 2'b10, S0, 1'b1);

        send(8'h15);
        tick(1);                                  // E2: transfer
        check("listo_drop", {7'd0, Listo}, 8'd0);
        DatoValido = 1'b0;

        tick(3);                                  // E5: DECENAS, still 00
        check_out("old_tens0", AN_T0, SEG_T0, 1'b0);

        tick(4);                                  // E9: boundary, 15 shown
        check_out("units5", 2'b10, S5, 1'b1);

        tick(4);                                  // E13: DECENAS
        check_out("tens1", 2'b01, S1, 1'b1);

        // 15 then 07 held while Listo=0.
        send(8'h15);
        tick(1);                                  // E14: transfer 15
        check("listo_drop2", {7'd0, Listo}, 8'd0);
        send(8'h07);
        tick(3);                                  // E17: boundary, 07 ignored so far
        check_out("hold_units5", 2'b10, S5, 1'b1);
        tick(1);                                  // E18: 07 captured
        check("listo_drop3", {7'd0, Listo}, 8'd0);
        DatoValido = 1'b0;
        tick(3);                                  // E21: still 15 this frame
        check_out("hold_tens1", 2'b01, S1, 1'b0);
        tick(4);                                  // E25: 07 shown
        check_out("units7", 2'b10, S7, 1'b1);
        tick(4);                                  // E29: tens 0
        check_out("tens0", AN_T0, SEG_T0, 1'b1);

        // Non-BCD units nibble.
        send(8'h3C);
        tick(1);                                  // E30
        DatoValido = 1'b0;
        tick(3);                                  // E33
        check_out("units_dash", 2'b10, SDASH, 1'b1);
        tick(4);                                  // E37
        check_out("tens3", 2'b01, S3, 1'b1);

        // Transfer on the boundary edge itself.
        tick(3);                                  // E40: last DECENAS cycle
        check_out("tens3_last", 2'b01, S3, 1'b1);
        send(8'h42);
        tick(1);                                  // E41: boundary + transfer
        check_out("boundary_xfer", 2'b10, SDASH, 1'b0);
        DatoValido = 1'b0;
        tick(4);                                  // E45
        check_out("boundary_tens", 2'b01, S3, 1'b0);
        tick(4);                                  // E49: 42 shown
        check_out("units2", 2'b10, S2, 1'b1);
        tick(4);                                  // E53
        check_out("tens4", 2'b01, S4, 1'b1);

        // Asynchronous reset mid-DECENAS with data pending.
        send(8'h42);
        tick(1);                                  // E54: pending full
        DatoValido = 1'b0;
        check("pend_full", {7'd0, Listo}, 8'd0);
        #2;
        rst_n = 1'b0;
        #1;                                       // well before next edge
        check_out("async_reset", 2'b11, SOFF, 1'b0);
        tick(2);
        rst_n = 1'b1;
        #1;
        check_out("reinicio", 2'b11, SOFF, 1'b0);
        tick(1);
        check_out("post_units0", 2'b10, S0, 1'b1);
        tick(4);
        check_out("post_tens0", AN_T0, SEG_T0, 1'b1);
        tick(4);                                  // pending 42 was discarded
        check_out("post_frame2", 2'b10, S0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/controlador_display.md
CONTROLADOR_DISPLAY -- requirements
Module: controlador_display

Interface
REQ-001 Parameter DIV_REFRESCO, default 1000, meaning: clk cycles each digit is lit per scan slot; legal range 2..65535.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 DatoBCD  input  8  two packed BCD digits: [7:4] tens, [3:0] units.
REQ-005 DatoValido  input  1  producer asserts when DatoBCD is valid.
REQ-006 Listo  output  1  block can accept DatoBCD this cycle.
REQ-007 Segmentos  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-008 Anodos  output  2  active-low digit enables: bit0 units, bit1 tens.

Function
REQ-009 Transfer occurs on a rising edge with DatoValido=1 and Listo=1; DatoBCD is captured into a one-entry pending register.
REQ-010 Listo drops on the edge after a transfer and stays low while the pending register is full; DatoValido with Listo=0 is ignored, and the producer holds DatoBCD.
REQ-011 The pending value moves to the display register only at a frame boundary, defined as the edge entering UNIDADES; Listo rises on that same edge, so no frame shows mixed old/new digits.
REQ-012 FSM states: INICIO, UNIDADES, DECENAS; INICIO->UNIDADES on the first edge after reset release; UNIDADES<->DECENAS when the refresh counter reaches DIV_REFRESCO-1.
REQ-013 Refresh counter is 16 bits, counts 0..DIV_REFRESCO-1, wraps to 0 on each digit switch, and is held at 0 in INICIO.
REQ-014 In INICIO: Anodos=2'b11, Segmentos=7'h7F, Listo=0.
REQ-015 In UNIDADES: Anodos=2'b10 and Segmentos encode display[3:0]; in DECENAS: Anodos=2'b01 and Segmentos encode display[7:4].
REQ-016 Segmentos and Anodos are registered and change on the same edge as the state.
REQ-017 Encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-018 Nibble values 10..15 (non-BCD) display a dash, 0111111.
REQ-019 A transfer coinciding with the frame-boundary edge is captured into pending and is shown from the next frame.

Reset
REQ-020 While rst_n=0: state=INICIO, counter=0, display and pending registers=8'h00, pending flag=0, Listo=0, Anodos=2'b11, Segmentos=7'h7F.
REQ-021 Reset asserted mid-scan or with pending data discards all data immediately; there is no partial-frame completion.

Configuration
REQ-022 Macro BLANQUEO_CEROS_EN defined: in DECENAS with display[7:4]=0, Anodos=2'b11 and Segmentos=7'h7F, while slot timing is unchanged.
REQ-023 Macro BLANQUEO_CEROS_EN undefined: tens digit 0 is displayed as 1000000.

Structure
REQ-024 Package display_pkg holds: state enum, segment constants (digits 0-9, dash, blank), anode constants, and the refresh counter width.
REQ-025 Sub-module bcd_a_7seg holds the combinational 4-bit to 7-segment encoding per REQ-017/018; controlador_display instantiates it once, with the nibble muxed by state.

Verification (bench uses DIV_REFRESCO=4)
REQ-026 Release reset, then 1 cycle -> INICIO outputs as REQ-014; next edge UNIDADES, Anodos=10, Segmentos=1000000, Listo=1.
REQ-027 Send 8'h15 while Listo=1 -> Listo=0 next cycle; at the next UNIDADES entry, units=0010010, then after 4 cycles DECENAS=1111001, Listo=1.
REQ-028 Send 8'h15, then hold DatoValido with 8'h07 while Listo=0 -> 8'h07 captured only after Listo rises; 15 is shown for one full frame first.
REQ-029 Send 8'h3C -> units slot 0111111 (dash), tens slot 0110000.
REQ-030 Send 8'h07: with BLANQUEO_CEROS_EN, DECENAS gives Anodos=11/Segmentos=7F; without it, Anodos=01/Segmentos=1000000.
REQ-031 Assert rst_n=0 asynchronously mid-DECENAS with pending 8'h42 -> outputs reach reset values before the next edge; after release, display shows 00.
